// File: rtl/chacha20_xor_stream_pkg.sv
// Constants and state encoding shared by the ChaCha20 stream XOR controller,
// its keystream buffer and the keystream generator side.
package chacha20_xor_stream_pkg;

    localparam int          CHACHA_BLOCK_W = 512;
    localparam int          CHACHA_WORDS   = 16;
    localparam int          WORD_IDX_W     = $clog2(CHACHA_WORDS);
    localparam logic [31:0] CTR_MAX        = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    // Expand per-byte enables into a word mask; keep[3] covers bits [31:24].
    function automatic logic [31:0] keep_to_mask(input logic [3:0] keep);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{keep[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/chacha20_xor_stream_if.sv
// Message-in, message-out and keystream-request signal bundle of the XOR stream.
interface chacha20_xor_stream_if;
    import chacha20_xor_stream_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_data;
    logic [3:0]                in_keep;
    logic                      in_last;

    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_data;
    logic [3:0]                out_keep;
    logic                      out_last;

    logic                      ks_req;
    logic [31:0]               ks_counter;
    logic                      ks_valid;
    logic [CHACHA_BLOCK_W-1:0] ks_block;

    modport slave (
        input  in_valid, in_data, in_keep, in_last,
        output in_ready,
        output out_valid, out_data, out_keep, out_last,
        input  out_ready,
        output ks_req, ks_counter,
        input  ks_valid, ks_block
    );

    modport master (
        output in_valid, in_data, in_keep, in_last,
        input  in_ready,
        input  out_valid, out_data, out_keep, out_last,
        output out_ready,
        input  ks_req, ks_counter,
        output ks_valid, ks_block
    );
endinterface

// File: rtl/chacha20_ks_buf.sv
// Holds one 512-bit keystream block and hands it out one 32-bit word at a time.
module chacha20_ks_buf
    import chacha20_xor_stream_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [CHACHA_BLOCK_W-1:0] block_i,
    input  logic                      advance,
    output logic [31:0]               word_out,
    output logic                      last_word
);

    logic [CHACHA_BLOCK_W-1:0] block_q, block_d;
    logic [WORD_IDX_W-1:0]     word_idx_q, word_idx_d;
    logic [31:0]               words [CHACHA_WORDS];

    always_comb begin
        block_d    = block_q;
        word_idx_d = word_idx_q;
        if (load) begin
            block_d    = block_i;
            word_idx_d = '0;
        end else if (advance) begin
            word_idx_d = word_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            block_q    <= '0;
            word_idx_q <= '0;
        end else begin
            block_q    <= block_d;
            word_idx_q <= word_idx_d;
        end
    end

    // Word 0 is the first four stream bytes, which sit at the top of the block.
    genvar gi;
    generate
        for (gi = 0; gi < CHACHA_WORDS; gi++) begin : g_word
            assign words[gi] = block_q[CHACHA_BLOCK_W-1-32*gi -: 32];
        end
    endgenerate

    assign word_out  = words[word_idx_q];
    assign last_word = (word_idx_q == WORD_IDX_W'(CHACHA_WORDS - 1));

endmodule

// File: rtl/chacha20_xor_stream.sv
// Message XOR engine: requests keystream blocks by counter and XORs them into
// the word stream, one word per clock inside a block.
module chacha20_xor_stream
    import chacha20_xor_stream_pkg::*;
#(
    parameter bit ALLOW_CTR_WRAP = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [31:0]                 init_counter,
    output logic                        busy,
    output logic                        ctr_wrap,
    chacha20_xor_stream_if.slave        bus
);

    state_e      state_q, state_d;
    logic [31:0] counter_q, counter_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [3:0]  out_keep_q, out_keep_d;
    logic        out_last_q, out_last_d;
    logic        ctr_wrap_q, ctr_wrap_d;

    logic        in_ready;
    logic        in_fire;
    logic        out_fire;
    logic        buf_load;
    logic        buf_advance;
    logic [31:0] ks_word;
    logic        last_word;

    chacha20_ks_buf u_ks_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .block_i   (bus.ks_block),
        .advance   (buf_advance),
        .word_out  (ks_word),
        .last_word (last_word)
    );

    assign in_ready = (state_q == ST_STREAM) && (!out_valid_q || bus.out_ready);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;
    // Busy also covers a word still waiting in the output register after a wrap halt.
    assign busy     = (state_q != ST_IDLE) || out_valid_q;

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        ctr_wrap_d  = ctr_wrap_q;
        buf_load    = 1'b0;
        buf_advance = 1'b0;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = (bus.in_data ^ ks_word) & keep_to_mask(bus.in_keep);
            out_keep_d  = bus.in_keep;
            out_last_d  = bus.in_last;
            buf_advance = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !busy) begin
                    counter_d  = init_counter;
                    ctr_wrap_d = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.ks_valid) begin
                    buf_load = 1'b1;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (in_fire) begin
                    if (bus.in_last) begin
                        state_d = ST_DRAIN;
                    end else if (last_word) begin
                        // Block exhausted: fetch the next one, unless the counter would wrap.
                        if (counter_q == CTR_MAX && !ALLOW_CTR_WRAP) begin
                            ctr_wrap_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            counter_d = counter_q + 32'd1;
                            state_d   = ST_REQ;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            ctr_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            ctr_wrap_q  <= ctr_wrap_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_keep   = out_keep_q;
    assign bus.out_last   = out_last_q;
    assign bus.ks_req     = (state_q == ST_REQ);
    assign bus.ks_counter = counter_q;
    assign ctr_wrap       = ctr_wrap_q;

endmodule
